// File: rtl/fpaddsub_pkg.sv
// Shared widths, sideband layout and stage record types for the FP add/sub datapath.
// Consumed by the normalization pipe and its leading-zero counter.
package fpaddsub_pkg;

  localparam int SUM_W   = 27;
  localparam int FRAC_W  = 23;
  localparam int EXP_W   = 8;
  localparam int NORME_W = 9;
  localparam int SIDE_W  = 9;
  localparam int LZC_W   = 5;
  localparam int EXT_W   = 10;
  localparam int BIAS    = 127;

  // Sideband layout {Sa, Sb, Ctrl, MaxAB, InputExc[4:0]}
  localparam int SIDE_EXC_LSB = 0;
  localparam int SIDE_EXC_W   = 5;
  localparam int SIDE_MAXAB   = 5;
  localparam int SIDE_CTRL    = 6;
  localparam int SIDE_SB      = 7;
  localparam int SIDE_SA      = 8;

  typedef struct packed {
    logic                 sa;
    logic                 sb;
    logic                 ctrl;
    logic                 max_ab;
    logic [SIDE_EXC_W-1:0] input_exc;
  } side_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             sticky;
    logic [EXP_W-1:0] e;
    logic             carry;
    logic [LZC_W-1:0] lzc;
    logic             zero;
  } stage1_t;

  typedef struct packed {
    logic [FRAC_W-1:0]  norm_m;
    logic [NORME_W-1:0] norm_e;
    logic               r;
    logic               s;
    logic               neg_e;
    logic               zero_sum;
  } norm_t;

endpackage

// File: rtl/fpaddsub_lzc26.sv
// Combinational leading-zero counter over a 26-bit significand window.
// Returns 26 when the whole window is zero.
module fpaddsub_lzc26
  import fpaddsub_pkg::*;
(
  input  logic [25:0]      din,
  output logic [LZC_W-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = LZC_W'(26);
    found = 1'b0;
    for (int i = 25; i >= 0; i--) begin
      if (!found && din[i]) begin
        cnt   = LZC_W'(25 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpaddsub_normalize_pipe.sv
// Two-stage normalization between the significand adder and the rounder.
// Backpressure is enabled by defining FPADDSUB_NORM_STALL_EN; otherwise stages advance every cycle.
module fpaddsub_normalize_pipe
  import fpaddsub_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_W-1:0]     in_sum,
  input  logic                 in_sticky,
  input  logic [EXP_W-1:0]     in_e,
  input  logic [SIDE_W-1:0]    in_side,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAC_W-1:0]    NormM,
  output logic [NORME_W-1:0]   NormE,
  output logic                 R,
  output logic                 S,
  output logic                 NegE,
  output logic                 ZeroSum,
  output logic [SIDE_W-1:0]    out_side
);

  // Shift-left normalization with 10-bit signed exponent; a carry-out ignores lzc.
  function automatic norm_t normalize(input stage1_t st);
    norm_t                    n;
    logic [23:0]              sig24;
    logic [25:0]              sh;
    logic [LZC_W-1:0]         lzc_eff;
    logic signed [EXT_W-1:0]  e_ext;
    logic                     rb;
    logic                     sb;
    n       = '0;
    lzc_eff = st.carry ? '0 : st.lzc;
    sh      = st.sum[25:0] << lzc_eff;
    e_ext   = signed'({2'b00, st.e}) + signed'({9'd0, st.carry})
              - signed'({5'd0, lzc_eff});
    if (st.carry) begin
      sig24 = st.sum[26:3];
      rb    = st.sum[2];
      sb    = (|st.sum[1:0]) | st.sticky;
    end else begin
      sig24 = sh[25:2];
      rb    = sh[1];
      sb    = sh[0] | st.sticky;
    end
    if (st.zero) begin
      n.zero_sum = 1'b1;
    end else begin
      n.norm_m = sig24[FRAC_W-1:0];
      n.neg_e  = (e_ext <= 10'sd0);
      n.norm_e = n.neg_e ? '0 : e_ext[NORME_W-1:0];
      n.r      = rb;
      n.s      = sb;
    end
    return n;
  endfunction

  logic             s2_adv;
  logic [LZC_W-1:0] lzc_in;

  logic             vld_p1_q, vld_p1_d;
  stage1_t          st_p1_q, st_p1_d;
  logic [SIDE_W-1:0] side_p1_q, side_p1_d;

  logic             vld_p2_q, vld_p2_d;
  norm_t            norm_p2_q, norm_p2_d;
  logic [SIDE_W-1:0] side_p2_q, side_p2_d;

  fpaddsub_lzc26 u_lzc (
    .din (in_sum[25:0]),
    .cnt (lzc_in)
  );

`ifdef FPADDSUB_NORM_STALL_EN
  assign s2_adv   = ~vld_p2_q | out_ready;
  assign in_ready = ~vld_p1_q | s2_adv;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign s2_adv   = 1'b1;
  assign in_ready = 1'b1;
`endif

  always_comb begin
    vld_p1_d  = vld_p1_q;
    st_p1_d   = st_p1_q;
    side_p1_d = side_p1_q;
    vld_p2_d  = vld_p2_q;
    norm_p2_d = norm_p2_q;
    side_p2_d = side_p2_q;

    // Stage 1: capture the raw sum and precompute carry, lzc and exact-zero
    if (in_ready) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        st_p1_d.sum    = in_sum;
        st_p1_d.sticky = in_sticky;
        st_p1_d.e      = in_e;
        st_p1_d.carry  = in_sum[SUM_W-1];
        st_p1_d.lzc    = lzc_in;
        st_p1_d.zero   = (in_sum == '0) & ~in_sticky;
        side_p1_d      = in_side;
      end
    end

    // Stage 2: normalized fraction, exponent and flags
    if (s2_adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        norm_p2_d = normalize(st_p1_q);
        side_p2_d = side_p1_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      st_p1_q   <= '0;
      side_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      norm_p2_q <= '0;
      side_p2_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      st_p1_q   <= st_p1_d;
      side_p1_q <= side_p1_d;
      vld_p2_q  <= vld_p2_d;
      norm_p2_q <= norm_p2_d;
      side_p2_q <= side_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign NormM     = norm_p2_q.norm_m;
  assign NormE     = norm_p2_q.norm_e;
  assign R         = norm_p2_q.r;
  assign S         = norm_p2_q.s;
  assign NegE      = norm_p2_q.neg_e;
  assign ZeroSum   = norm_p2_q.zero_sum;
  assign out_side  = side_p2_q;

endmodule

// File: tb/tb_fpaddsub_normalize_pipe.sv
// Self-checking bench for fpaddsub_normalize_pipe: directed vectors, handshake and reset
// scenarios, and random beats against a scoreboard fed by an arithmetic reference model.
module tb_fpaddsub_normalize_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_sum;
  logic        in_sticky;
  logic [7:0]  in_e;
  logic [8:0]  in_side;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] NormM;
  logic [8:0]  NormE;
  logic        R, S, NegE, ZeroSum;
  logic [8:0]  out_side;

`ifdef FPADDSUB_NORM_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  always #5 clk = ~clk;

  fpaddsub_normalize_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_sticky(in_sticky), .in_e(in_e), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready),
    .NormM(NormM), .NormE(NormE), .R(R), .S(S), .NegE(NegE), .ZeroSum(ZeroSum),
    .out_side(out_side)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [44:0] exp_q[$];
  bit          dir_use  = 1'b0;
  logic [44:0] dir_exp;

  function automatic logic [44:0] outs();
    return {out_side, ZeroSum, NegE, S, R, NormE, NormM};
  endfunction

  function automatic logic [44:0] mk(input logic [8:0] sd, input bit z, input bit ng,
                                     input bit s, input bit r, input logic [8:0] ne,
                                     input logic [22:0] nm);
    return {sd, z, ng, s, r, ne, nm};
  endfunction

  // Reference: value-level normalization using integer arithmetic.
  function automatic logic [44:0] model(input logic [26:0] sm, input logic st,
                                        input logic [7:0] e, input logic [8:0] sd);
    longint      m, shv, sig;
    int          lz, ee;
    bit          r, s, ng;
    logic [8:0]  ne;
    if (sm == 27'd0 && !st) return {sd, 1'b1, 35'd0};
    if (sm[26]) begin
      sig = longint'(sm) >> 3;
      r   = sm[2];
      s   = (sm[1:0] != 2'b00) || st;
      ee  = int'(e) + 1;
    end else begin
      m  = longint'(sm[25:0]);
      lz = 26;
      for (int b = 25; b >= 0; b--)
        if (lz == 26 && ((m >> b) & 1) == 1) lz = 25 - b;
      shv = (m << lz) & 64'h3ffffff;
      sig = shv >> 2;
      r   = shv[1];
      s   = shv[0] | st;
      ee  = int'(e) - lz;
    end
    ng = (ee <= 0);
    ne = ng ? 9'd0 : 9'(ee);
    return {sd, 1'b0, ng, s, r, ne, 23'(sig)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at negedge, sample just after, score outputs, record accepts.
  task automatic cyc(input bit v, input bit ordy, input logic [26:0] sm, input bit st,
                     input logic [7:0] e, input logic [8:0] sd, output bit acc);
    @(negedge clk);
    in_valid = v; out_ready = ordy; in_sum = sm; in_sticky = st; in_e = e; in_side = sd;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'd0);
      else begin
        check("beat", 64'(outs()), 64'(exp_q[0]));
        if (out_ready || !STALL) void'(exp_q.pop_front());
      end
    end
    acc = v && in_ready;
    if (acc) begin
      exp_q.push_back(dir_use ? dir_exp : model(sm, st, e, sd));
      dir_use = 1'b0;
    end
  endtask

  task automatic dir(input logic [26:0] sm, input bit st, input logic [7:0] e,
                     input logic [8:0] sd, input logic [44:0] ex);
    bit acc;
    dir_exp = ex; dir_use = 1'b1;
    cyc(1'b1, 1'b1, sm, st, e, sd, acc);
    check("dir_accept", 64'(acc), 64'd1);
  endtask

  function automatic logic [26:0] rsum();
    logic [26:0] x;
    x = 27'($urandom);
    return x >> $urandom_range(0, 27);
  endfunction

  task automatic drain();
    bit acc;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++)
      cyc(1'b0, 1'b1, 27'd0, 1'b0, 8'd0, 9'd0, acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          nacc;
    bit          pend;
    logic [26:0] p_sum;
    bit          p_st;
    logic [7:0]  p_e;
    logic [8:0]  p_sd;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_sticky = 1'b0; in_e = '0; in_side = '0;
    @(negedge clk); @(negedge clk); #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'(outs()), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst = 1'b0;

    // Normal value, with latency check
    dir(27'h2000000, 1'b0, 8'd127, 9'h0a5, mk(9'h0a5, 0, 0, 0, 0, 9'd127, 23'd0));
    cyc(1'b0, 1'b1, 27'd0, 1'b0, 8'd0, 9'd0, acc);
    check("latency_not_early", 64'(out_valid), 64'd0);
    cyc(1'b0, 1'b1, 27'd0, 1'b0, 8'd0, 9'd0, acc);
    check("latency_two", 64'(out_valid), 64'd1);

    // Back-to-back directed vectors
    dir(27'h4000004, 1'b0, 8'd127, 9'h1ff, mk(9'h1ff, 0, 0, 0, 1, 9'd128, 23'd0));
    dir(27'h0000008, 1'b0, 8'd100, 9'h003, mk(9'h003, 0, 0, 0, 0, 9'd78, 23'd0));
    dir(27'h0000008, 1'b0, 8'd10,  9'h100, mk(9'h100, 0, 1, 0, 0, 9'd0, 23'd0));
    dir(27'h0000000, 1'b0, 8'd55,  9'h055, mk(9'h055, 1, 0, 0, 0, 9'd0, 23'd0));
    dir(27'h0000000, 1'b1, 8'd127, 9'h0f0, mk(9'h0f0, 0, 0, 1, 0, 9'd101, 23'd0));
    dir(27'h3ffffff, 1'b0, 8'd255, 9'h011, mk(9'h011, 0, 0, 1, 1, 9'd255, 23'h7fffff));
    dir(27'h7ffffff, 1'b0, 8'd255, 9'h022, mk(9'h022, 0, 0, 1, 1, 9'd256, 23'h7fffff));
    dir(27'h0000001, 1'b0, 8'd25,  9'h044, mk(9'h044, 0, 1, 0, 0, 9'd0, 23'd0));
    drain();

`ifdef FPADDSUB_NORM_STALL_EN
    // Backpressure: only two beats fit while out_ready is low
    nacc = 0;
    cyc(1'b1, 1'b0, 27'h2000000, 1'b0, 8'd1, 9'h001, acc); nacc += int'(acc);
    cyc(1'b1, 1'b0, 27'h4000004, 1'b0, 8'd2, 9'h002, acc); nacc += int'(acc);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 27'h0000008, 1'b0, 8'd100, 9'h003, acc); nacc += int'(acc);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid_held", 64'(out_valid), 64'd1);
    end
    check("bp_accepted_two", 64'(nacc), 64'd2);
    cyc(1'b1, 1'b1, 27'h0000008, 1'b0, 8'd100, 9'h003, acc);
    check("bp_third_accepted", 64'(acc), 64'd1);
    drain();
`else
    // out_ready is ignored: beats still leave and in_ready stays high
    cyc(1'b1, 1'b0, 27'h2000000, 1'b0, 8'd1, 9'h001, acc);
    check("nostall_in_ready", 64'(in_ready), 64'd1);
    cyc(1'b1, 1'b0, 27'h4000004, 1'b0, 8'd2, 9'h002, acc);
    cyc(1'b0, 1'b0, 27'd0, 1'b0, 8'd0, 9'd0, acc);
    cyc(1'b0, 1'b0, 27'd0, 1'b0, 8'd0, 9'd0, acc);
    check("nostall_drained", 64'(exp_q.size()), 64'd0);
`endif

    // Full pipe streaming with out_ready high
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, rsum(), 1'($urandom), 8'($urandom), 9'($urandom), acc);
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end

    // Reset mid-stream drops in-flight beats
    @(negedge clk); in_valid = 1'b0; #2; rst = 1'b1; #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_outputs", 64'(outs()), 64'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0; #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_no_out", 64'(out_valid), 64'd0);

    // Random traffic with random backpressure
    pend = 1'b0; p_sum = '0; p_st = 1'b0; p_e = '0; p_sd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend = 1'b1; p_sum = rsum(); p_st = 1'($urandom);
        p_e = 8'($urandom); p_sd = 9'($urandom);
      end
      cyc(pend, 1'($urandom_range(0, 3) != 0), p_sum, p_st, p_e, p_sd, acc);
      if (acc) pend = 1'b0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fpaddsub_normalize_pipe.md
# fpaddsub_normalize_pipe

Two-stage pipelined normalization stage of the FP add/sub datapath. It sits between the significand adder and the rounding stage. It takes the raw 27-bit sum plus sticky and the larger operand's exponent, and produces the normalized 23-bit fraction, 9-bit exponent, round/sticky bits, and the NegE/ZeroSum flags the rounding stage consumes. Sideband fields travel alongside under a valid/ready handshake.

## Interface
Parameters:
- none (all widths are fixed single precision, taken from the package).

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_sum  in  27  [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] round.
- in_sticky  in  1  OR of bits shifted out during alignment.
- in_e  in  8  larger operand's biased exponent.
- in_side  in  9  {Sgn, Sa, Sb, Ctrl, MaxAB, InputExc[4:0]} minus Sgn packing, defined in the package; carried unchanged.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- NormM  out  23  normalized fraction, hidden bit dropped.
- NormE  out  9  normalized exponent.
- R  out  1  round bit.
- S  out  1  sticky bit.
- NegE  out  1  exponent ≤ 0.
- ZeroSum  out  1  exact zero result.
- out_side  out  9  in_side, delayed with its beat.

## Operation
- Stage 1, on accept:
  - registers in_sum, in_sticky, in_e, in_side and carry = in_sum[26];
  - registers lzc = leading-zero count of in_sum[25:0], range 0..26;
  - registers zero = (in_sum == 0) & ~in_sticky.
- Stage 2, on advance, has three cases:
  - **carry = 1:** sig24 = sum[26:3]; R = sum[2]; S = |sum[1:0] | sticky; E = in_e + 1.
  - **carry = 0, zero = 0:** sh = sum[25:0] << lzc; sig24 = sh[25:2]; R = sh[1]; S = sh[0] | sticky; E = in_e − lzc.
  - **zero = 1:** NormM = 0, NormE = 0, R = S = 0, ZeroSum = 1, NegE = 0.
- Exponent arithmetic is done in 10-bit two's complement, as {2'b0, in_e} + carry − lzc.
  - NegE = (E ≤ 0).
  - If NegE = 1: NormE = 0 and NormM = sig24[22:0], with no denormalizing shift.
  - Otherwise NormE = E[8:0]. NormE = 255 (or 256) is passed through; overflow detection belongs to the rounding stage.
- NormM = sig24[22:0] whenever zero = 0.
- Sideband fields are never modified.

## Timing
- Latency: 2 cycles from the accept edge to out_valid with no stall. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers when valid & ready are both high at an edge.
  - in_ready = ~s1_valid | s2_adv, where s2_adv = ~s2_valid | out_ready.
  - out_valid is not retracted and outputs hold stable while out_ready = 0.
- Capacity is 2 beats. With out_ready held low, in_ready falls after two accepts. Beats leave in order with no loss or duplication.
- Full pipe with in_valid and out_ready both high: the beat shifts through, in_ready stays 1, and throughput is maintained.
- Reset, whether at start-up or mid-operation:
  - s1_valid, s2_valid and out_valid go to 0 immediately; in-flight beats are dropped.
  - All datapath outputs (NormM, NormE, R, S, NegE, ZeroSum, out_side) reset to 0.
  - in_ready = 1 after reset.

## Configuration
- FPADDSUB_NORM_STALL_EN defined: full valid/ready backpressure as described above.
- FPADDSUB_NORM_STALL_EN undefined:
  - out_ready is ignored and in_ready is tied to 1;
  - the stages advance every cycle and the valid bits are a plain 2-cycle shift;
  - the datapath result is identical to the defined case.

## Structure
- Shared package fpaddsub_pkg holds:
  - width constants: SUM_W = 27, FRAC_W = 23, EXP_W = 8, NORME_W = 9, SIDE_W = 9;
  - the sideband field offsets;
  - the bias constant 127.
- One sub-module: fpaddsub_lzc26, a combinational leading-zero counter. Input 26 bits; output 5-bit count; returns 26 for all-zero input.

## Test plan
- **Normal value:** in_sum = 27'h2000000, in_e = 127, sticky = 0 -> two cycles later NormM = 0, NormE = 127, R = 0, S = 0, NegE = 0, ZeroSum = 0.
- **Carry-out:** in_sum = 27'h4000004, in_e = 127 -> NormM = 0, NormE = 128, R = 1, S = 0.
- **Massive cancellation:** in_sum = 27'h0000008, in_e = 100 -> lzc = 22, NormE = 78, NormM = 0, R = 0, S = 0.
- **Underflow:** in_sum = 27'h0000008, in_e = 10 -> NegE = 1, NormE = 0.
- **Exact zero:** in_sum = 0, sticky = 0 -> ZeroSum = 1, NormM = 0, NormE = 0. Also in_sum = 0 with sticky = 1 -> ZeroSum = 0.
- **Backpressure and reset:**
  - With FPADDSUB_NORM_STALL_EN, hold out_ready = 0 and offer 3 beats -> only 2 accepted, in_ready = 0, outputs stable.
  - Release out_ready -> all 3 beats emerge in order.
  - Assert rst mid-stream -> out_valid = 0 the same cycle and in_ready = 1 after reset.
